// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter.
// Holds the tag carried alongside each in-flight multiply.
package mult_share_pkg;
   localparam int NREQ_DEF    = 4;
   localparam int WIDTH_DEF   = 8;
   localparam int MUL_LAT_DEF = 1;
   localparam int ID_MAX_W    = 3;   // enough for NREQ up to 8

   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic                valid;
      logic [ID_MAX_W-1:0] id;
   } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a rotating pointer.
// The pointer moves past the winner only when the caller accepts the grant.
module rr_arbiter
   import mult_share_pkg::*;
#(
   parameter  int NREQ = NREQ_DEF,
   localparam int IDW  = id_w(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gidx
);
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] idx;
   logic           hit;

   always_comb begin
      gnt  = '0;
      gidx = '0;
      hit  = 1'b0;
      idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(ptr) + k) % NREQ);
         if (!hit && req[idx]) begin
            hit      = 1'b1;
            gnt[idx] = 1'b1;
            gidx     = idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ptr <= '0;
      else if (advance)
         ptr <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
   end
endmodule

// File: rtl/mult_share_arbiter.sv
// Time-shares one external pipelined multiplier among NREQ requesters.
// Each issue is tagged with its requester id; the tag rides alongside the multiply.
module mult_share_arbiter
   import mult_share_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int WIDTH   = WIDTH_DEF,
   parameter int MUL_LAT = MUL_LAT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] op_a,
   input  logic [NREQ*WIDTH-1:0] op_b,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      mul_a,
   output logic [WIDTH-1:0]      mul_b,
   input  logic [2*WIDTH-1:0]    mul_p,
   output logic [NREQ-1:0]       res_valid,
   output logic [2*WIDTH-1:0]    res_data,
   output logic                  busy
);
   localparam int IDW = id_w(NREQ);

   logic [IDW-1:0]   gidx;
   logic             issue;
   logic             busy_nxt;
   tag_t [MUL_LAT:0] pipe;

   assign issue = |gnt;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (issue),
      .gnt     (gnt),
      .gidx    (gidx)
   );

   // pipe[0] marks operands presented to the multiplier; pipe[MUL_LAT] lines up
   // with the cycle its product is stable on mul_p.
   always_comb begin
      busy_nxt = issue;
      for (int k = 0; k <= MUL_LAT; k++)
         busy_nxt = busy_nxt | pipe[k].valid;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mul_a     <= '0;
         mul_b     <= '0;
         pipe      <= '0;
         res_valid <= '0;
         res_data  <= '0;
         busy      <= 1'b0;
      end else begin
         if (issue) begin
            mul_a <= op_a[gidx*WIDTH +: WIDTH];
            mul_b <= op_b[gidx*WIDTH +: WIDTH];
         end
         pipe[0].valid <= issue;
         pipe[0].id    <= ID_MAX_W'(gidx);
         for (int k = 1; k <= MUL_LAT; k++)
            pipe[k] <= pipe[k-1];
         res_valid <= '0;
         if (pipe[MUL_LAT].valid) begin
            res_valid <= NREQ'(1) << pipe[MUL_LAT].id;
            res_data  <= mul_p;
         end
         busy <= busy_nxt;
      end
   end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized and directed bench for mult_share_arbiter against a queue-based model.
module tb_mult_share_arbiter;
   localparam int N = 4;
   localparam int W = 8;
   localparam int L = 1;

   logic           clk = 1'b1;
   logic           rst = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] op_a = '0, op_b = '0;
   logic [N-1:0]   gnt, res_valid;
   logic [W-1:0]   mul_a, mul_b;
   logic [2*W-1:0] mul_p = '0, res_data;
   logic           busy;

   mult_share_arbiter #(.NREQ(N), .WIDTH(W), .MUL_LAT(L)) dut (
      .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .gnt(gnt),
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .res_valid(res_valid),
      .res_data(res_data), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) mul_p <= 16'(mul_a) * 16'(mul_b);

   typedef struct { int id; int prod; int due; } item_t;
   item_t        q[$];
   int           mptr = 0, edge_n = 0, n_chk = 0, n_fail = 0;
   int           dcnt[N];
   logic [15:0]  e_rd = '0;
   logic [7:0]   e_ma = '0, e_mb = '0;
   logic [N-1:0] lgnt = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] mgnt(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (p + k) % N;
         if (r[i]) return N'(1) << i;
      end
      return '0;
   endfunction

   function automatic logic [7:0] rnd_op();
      return ($urandom % 8 == 0) ? 8'd255 : 8'($urandom % 256);
   endfunction

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      op_a[i*W +: W] = a;
      op_b[i*W +: W] = b;
   endtask

   // One clock: check gnt mid-cycle, advance model at the edge, check registered outputs.
   task automatic cycle();
      logic [N-1:0] eg, erv;
      item_t        it;
      int           gi;
      @(negedge clk);
      eg = mgnt(req, mptr);
      chk("gnt", 32'(gnt), 32'(eg));
      for (int i = 0; i < N; i++) dcnt[i] += int'(gnt[i]);
      @(posedge clk);
      edge_n++;
      if (eg != '0) begin
         gi = 0;
         for (int i = 0; i < N; i++) if (eg[i]) gi = i;
         e_ma = op_a[gi*W +: W];
         e_mb = op_b[gi*W +: W];
         q.push_back('{gi, int'(e_ma) * int'(e_mb), edge_n + L + 1});
         mptr = (gi + 1) % N;
      end
      lgnt = eg;
      #1;
      erv = '0;
      if (q.size() > 0 && q[0].due == edge_n) begin
         it   = q.pop_front();
         erv  = N'(1) << it.id;
         e_rd = 16'(it.prod);
      end
      chk("res_valid", 32'(res_valid), 32'(erv));
      chk("res_data", 32'(res_data), 32'(e_rd));
      chk("busy", 32'(busy), 32'((q.size() > 0) || (erv != '0)));
      chk("mul_a", 32'(mul_a), 32'(e_ma));
      chk("mul_b", 32'(mul_b), 32'(e_mb));
   endtask

   task automatic model_reset();
      q.delete();
      mptr = 0; e_rd = '0; e_ma = '0; e_mb = '0;
   endtask

   task automatic drain();
      req = '0;
      repeat (L + 3) cycle();
   endtask

   initial begin
      int c0;
      for (int i = 0; i < N; i++) dcnt[i] = 0;
      // 1: reset state and idle
      #2;
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mul_a", 32'(mul_a), 32'd0);
      #3 rst = 1'b1;
      #1;
      chk("idle_gnt", 32'(gnt), 32'd0);
      repeat (3) cycle();

      // 2: single op
      req = 4'b0001; set_op(0, 8'd10, 8'd5);
      cycle();
      drain();

      // 3: all four at once, held until granted
      set_op(0, 8'd100, 8'd7); set_op(1, 8'd200, 8'd200);
      set_op(2, 8'd99, 8'd10); set_op(3, 8'd88, 8'd99);
      req = 4'b1111;
      repeat (4) begin cycle(); req &= ~lgnt; end
      drain();

      // 4: move pointer to 2, then req=0011 wraps to 0
      req = 4'b0010; set_op(1, 8'd3, 8'd4);
      cycle();
      req = 4'b0011; set_op(0, 8'd255, 8'd255); set_op(1, 8'd17, 8'd19);
      repeat (2) begin cycle(); req &= ~lgnt; end
      drain();
      // fairness: everybody requests continuously with fresh operands
      for (int i = 0; i < N; i++) dcnt[i] = 0;
      req = '1;
      repeat (4 * N) begin
         cycle();
         for (int i = 0; i < N; i++) if (lgnt[i]) set_op(i, rnd_op(), rnd_op());
      end
      for (int i = 0; i < N; i++) chk("rr_share", 32'(dcnt[i]), 32'(4));
      drain();

      // 5: reset one cycle after a grant drops the op and restarts the pointer
      req = 4'b0001; set_op(0, 8'd12, 8'd13);
      cycle();
      req = '0; rst = 1'b0;
      model_reset();
      #1;
      chk("rst5_busy", 32'(busy), 32'd0);
      chk("rst5_res_valid", 32'(res_valid), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) cycle();
      req = 4'b1111;
      repeat (4) begin cycle(); req &= ~lgnt; end
      drain();

      // 6: back-to-back issue from requester 3 alone
      c0 = dcnt[3];
      req = 4'b1000; set_op(3, rnd_op(), rnd_op());
      repeat (8) begin cycle(); set_op(3, rnd_op(), rnd_op()); end
      req = '0;
      chk("b2b_grants", 32'(dcnt[3] - c0), 32'd8);
      drain();

      // random traffic respecting the hold-until-granted handshake
      repeat (400) begin
         cycle();
         for (int i = 0; i < N; i++) begin
            if (lgnt[i]) begin
               if ($urandom % 2 == 0) set_op(i, rnd_op(), rnd_op());
               else req[i] = 1'b0;
            end else if (!req[i] && ($urandom % 3 == 0)) begin
               req[i] = 1'b1;
               set_op(i, rnd_op(), rnd_op());
            end
         end
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
